dcache_req_buffer: RTL and testbench
====================================

DCACHE_REQ_BUFFER -- requirements
Module: dcache_req_buffer

Purpose: request FIFO between the memory unit and the dcache interface; decouples issue from cache back-pressure, caps in-flight requests, supports kill and fence-drain.

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 Parameter MAX_INFLIGHT, default 8, cap on requests accepted by the cache but not yet responded.
REQ-003 Parameter TAG_W, default 7, request tag width.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 in_valid_i  in  1  upstream request valid.
REQ-007 in_ready_o  out  1  buffer can accept a request.
REQ-008 in_addr_i  in  64  request address (data_rs1).
REQ-009 in_wdata_i  in  64  store data (data_rs2).
REQ-010 in_op_i  in  5  operation code, passed through unchanged.
REQ-011 in_size_i  in  4  memory size, passed through unchanged.
REQ-012 in_tag_i  in  TAG_W  destination tag (rd).
REQ-013 out_valid_o  out  1  head entry presented downstream.
REQ-014 out_ready_i  in  1  downstream accepted (dcache ready, tag not busy).
REQ-015 out_addr_o, out_wdata_o, out_op_o, out_size_o, out_tag_o  out  64/64/5/4/TAG_W  head entry fields.
REQ-016 rsp_valid_i  in  1  cache response returned (one per accepted request).
REQ-017 kill_i  in  1  pipeline flush; discard all queued, not-yet-issued entries.
REQ-018 drain_i  in  1  fence request; level-sensitive.
REQ-019 drained_o  out  1  FIFO empty and zero in flight.
REQ-020 count_o  out  $clog2(DEPTH)+1  queued entries.
REQ-021 inflight_o  out  $clog2(MAX_INFLIGHT)+1  outstanding requests.

Function
REQ-022 Push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i; both evaluated on the same edge.
REQ-023 in_ready_o = (count < DEPTH | pop) & ~kill_i & ~drain_i; full FIFO still accepts when popping the same cycle.
REQ-024 out_valid_o = (count != 0) & (inflight < MAX_INFLIGHT) & ~kill_i.
REQ-025 out_* fields come directly from the head entry (registered storage, no combinational path from in_* to out_*); minimum latency push->out_valid_o is 1 cycle.
REQ-026 Entries leave in push order; read/write pointers wrap modulo DEPTH.
REQ-027 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-028 Out fields held stable while out_valid_o=1 and out_ready_i=0.
REQ-029 inflight next = inflight + pop - rsp_valid_i; simultaneous pop and response leave it unchanged.
REQ-030 rsp_valid_i when inflight=0 is ignored (counter saturates at 0); pop when inflight=MAX_INFLIGHT cannot occur (out_valid_o low).
REQ-031 kill_i: next cycle count=0 and pointers equal; no push or pop on a kill cycle; inflight unaffected (issued requests still return).
REQ-032 State machine: RUN (accepting), DRAIN (drain_i=1, pushes blocked, issue continues until drained), FENCED (drained_o=1 while drain_i held); drain_i low in any state -> RUN next cycle.
REQ-033 drained_o = (count==0) & (inflight==0); registered-state derived, combinational from counters only.

Reset
REQ-034 On rstn_i low, asynchronously: count=0, pointers=0, inflight=0, state RUN; outputs out_valid_o=0, in_ready_o=1 (if drain_i/kill_i low), drained_o=1, count_o=0, inflight_o=0.
REQ-035 Entry payload storage is not reset; out_* data values are don't-care while out_valid_o=0.
REQ-036 Reset asserted mid-operation discards all queued entries and zeroes inflight with no further out_valid_o.

Verification
REQ-037 Fill: push 4 reqs tags 1..4 with out_ready_i=0 -> count_o=4, in_ready_o=0; then out_ready_i=1 -> tags 1,2,3,4 issued in order, one per cycle.
REQ-038 Full with push+pop same cycle: count=4, push tag 5 while popping tag 1 -> accepted, count stays 4, order 2,3,4,5.
REQ-039 In-flight cap: MAX_INFLIGHT=8, no responses, 10 queued pushes -> exactly 8 pops, out_valid_o=0 after; one rsp_valid_i -> 9th issued next cycle.
REQ-040 Kill: 3 entries queued, 2 in flight, pulse kill_i -> count_o=0, inflight_o=2, no out_valid_o until new push.
REQ-041 Drain: drain_i=1 with 2 queued, 1 in flight -> in_ready_o=0, both issued, drained_o=1 only after all 3 responses; drain_i low -> in_ready_o=1 next cycle.
REQ-042 Async reset mid-burst: rstn_i low with count=3, inflight=5 -> immediately count_o=0, inflight_o=0, out_valid_o=0, drained_o=1.

Source files
------------

// File: rtl/dcache_req_buffer.sv
// Request FIFO between the memory unit and the dcache: buffers requests,
// caps outstanding cache requests, and supports pipeline kill and fence drain.
//
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   in_valid_i / in_ready_o       upstream handshake
//   in_addr_i, in_wdata_i,
//   in_op_i, in_size_i, in_tag_i  request payload
//   out_valid_o / out_ready_i     downstream (dcache) handshake
//   out_addr_o ... out_tag_o      head-entry payload
//   rsp_valid_i                   one cache response per issued request
//   kill_i                        flush all queued, not-yet-issued entries
//   drain_i / drained_o           fence request / buffer empty, nothing in flight
//   count_o, inflight_o           queued and outstanding request counts
module dcache_req_buffer #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int TAG_W        = 7
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [63:0]                     in_addr_i,
    input  logic [63:0]                     in_wdata_i,
    input  logic [4:0]                      in_op_i,
    input  logic [3:0]                      in_size_i,
    input  logic [TAG_W-1:0]                in_tag_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [63:0]                     out_addr_o,
    output logic [63:0]                     out_wdata_o,
    output logic [4:0]                      out_op_o,
    output logic [3:0]                      out_size_o,
    output logic [TAG_W-1:0]                out_tag_o,
    input  logic                            rsp_valid_i,
    input  logic                            kill_i,
    input  logic                            drain_i,
    output logic                            drained_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [IW-1:0] MAX_C   = IW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FENCED
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [IW-1:0]   inflight;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;
    logic            push;
    logic            pop;
    logic            rsp_take;
    logic            drained;

    // Payload storage is deliberately not reset.
    logic [63:0]      addr_q  [DEPTH];
    logic [63:0]      wdata_q [DEPTH];
    logic [4:0]       op_q    [DEPTH];
    logic [3:0]       size_q  [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];

    always_comb begin
        out_valid_o = (count != '0) & (inflight < MAX_C) & ~kill_i;
        pop         = out_valid_o & out_ready_i;
        // A full buffer still accepts when the head leaves this cycle.
        in_ready_o  = ((count < DEPTH_C) | pop) & ~kill_i & ~drain_i;
        push        = in_valid_i & in_ready_o;
        // Responses with nothing outstanding are dropped.
        rsp_take    = rsp_valid_i & (inflight != '0);
        drained     = (count == '0) & (inflight == '0);
    end

    assign drained_o   = drained;
    assign count_o     = count;
    assign inflight_o  = inflight;
    assign out_addr_o  = addr_q[rptr];
    assign out_wdata_o = wdata_q[rptr];
    assign out_op_o    = op_q[rptr];
    assign out_size_o  = size_q[rptr];
    assign out_tag_o   = tag_q[rptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wptr]  <= in_addr_i;
            wdata_q[wptr] <= in_wdata_i;
            op_q[wptr]    <= in_op_i;
            size_q[wptr]  <= in_size_i;
            tag_q[wptr]   <= in_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else if (kill_i) begin
            count <= '0;
            rptr  <= wptr;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Kill leaves this alone: issued requests still return.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inflight <= '0;
        end else begin
            case ({pop, rsp_take})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Fence tracking; pushes are blocked by drain_i directly, issue goes on.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= RUN;
        end else if (!drain_i) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= drained ? FENCED : DRAIN;
                DRAIN:   state <= drained ? FENCED : DRAIN;
                FENCED:  state <= FENCED;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_req_buffer.sv
// Self-checking bench for dcache_req_buffer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_dcache_req_buffer;

    localparam int DEPTH = 4;
    localparam int MAXI  = 8;
    localparam int TW    = 7;

    typedef struct packed {
        logic [63:0]   addr;
        logic [63:0]   wdata;
        logic [4:0]    op;
        logic [3:0]    size;
        logic [TW-1:0] tag;
    } req_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_addr = '0;
    logic [63:0]   in_wdata = '0;
    logic [4:0]    in_op = '0;
    logic [3:0]    in_size = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_addr;
    logic [63:0]   out_wdata;
    logic [4:0]    out_op;
    logic [3:0]    out_size;
    logic [TW-1:0] out_tag;
    logic          rsp_valid = 1'b0;
    logic          kill = 1'b0;
    logic          drain = 1'b0;
    logic          drained;
    logic [2:0]    count_o;
    logic [3:0]    inflight_o;

    req_t q[$];
    int   issued[$];
    int   infl = 0;
    int   npush = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dcache_req_buffer #(
        .DEPTH(DEPTH),
        .MAX_INFLIGHT(MAXI),
        .TAG_W(TW)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_addr_i(in_addr),
        .in_wdata_i(in_wdata),
        .in_op_i(in_op),
        .in_size_i(in_size),
        .in_tag_i(in_tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_addr_o(out_addr),
        .out_wdata_o(out_wdata),
        .out_op_o(out_op),
        .out_size_o(out_size),
        .out_tag_o(out_tag),
        .rsp_valid_i(rsp_valid),
        .kill_i(kill),
        .drain_i(drain),
        .drained_o(drained),
        .count_o(count_o),
        .inflight_o(inflight_o)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit v, input int tag);
        in_valid = v;
        in_tag   = TW'(tag);
        in_addr  = {$urandom, $urandom};
        in_wdata = {$urandom, $urandom};
        in_op    = 5'($urandom);
        in_size  = 4'($urandom);
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cyc();
        bit   ev, er, pop, push;
        req_t cur;
        @(negedge clk);
        ev   = (q.size() != 0) && (infl < MAXI) && !kill;
        pop  = ev && out_ready;
        er   = ((q.size() < DEPTH) || pop) && !kill && !drain;
        push = er && in_valid;
        cur  = '{in_addr, in_wdata, in_op, in_size, in_tag};
        check("out_valid", 64'(out_valid), 64'(ev));
        check("in_ready", 64'(in_ready), 64'(er));
        check("count", 64'(count_o), 64'(q.size()));
        check("inflight", 64'(inflight_o), 64'(infl));
        check("drained", 64'(drained), 64'(q.size() == 0 && infl == 0));
        if (ev) begin
            check("out_tag", 64'(out_tag), 64'(q[0].tag));
            check("out_addr", out_addr, q[0].addr);
            check("out_wdata", out_wdata, q[0].wdata);
            check("out_op", 64'(out_op), 64'(q[0].op));
            check("out_size", 64'(out_size), 64'(q[0].size));
        end
        @(posedge clk);
        infl = infl + int'(pop) - int'(rsp_valid && infl > 0);
        if (kill) begin
            q.delete();
        end else begin
            if (pop) begin
                issued.push_back(int'(q[0].tag));
                void'(q.pop_front());
            end
            if (push) begin
                q.push_back(cur);
                npush++;
            end
        end
        #1;
    endtask

    task automatic settle();
        int g = 0;
        in_valid = 0;
        kill = 0;
        drain = 0;
        out_ready = 1;
        rsp_valid = 1;
        while ((q.size() != 0 || infl != 0) && g < 60) begin
            cyc();
            g++;
        end
        check("settle_timeout", 64'(q.size() + infl), 64'd0);
        rsp_valid = 0;
        out_ready = 0;
    endtask

    task automatic fill(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1, first + i);
            cyc();
        end
        in_valid = 0;
    endtask

    initial begin
        int g;
        // Reset values
        #2;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_inflight", 64'(inflight_o), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_drained", 64'(drained), 64'd1);
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;

        // Fill then drain in order
        fill(1, 4);
        check("fill_count", 64'(count_o), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        issued.delete();
        out_ready = 1;
        for (int i = 0; i < 4; i++) cyc();
        check("fill_issued_n", 64'(issued.size()), 64'd4);
        for (int i = 0; i < issued.size(); i++)
            check("fill_order", 64'(issued[i]), 64'(i + 1));
        settle();

        // Full buffer with simultaneous push and pop
        fill(1, 4);
        issued.delete();
        out_ready = 1;
        set_in(1, 5);
        cyc();
        in_valid = 0;
        check("full_pp_count", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) cyc();
        check("full_pp_n", 64'(issued.size()), 64'd5);
        for (int i = 0; i < issued.size(); i++)
            check("full_pp_order", 64'(issued[i]), 64'(i + 1));
        settle();

        // In-flight cap
        issued.delete();
        npush = 0;
        fill(10, 4);
        out_ready = 1;
        g = 0;
        while (npush < 10 && g < 50) begin
            set_in(1, 10 + npush);
            cyc();
            g++;
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) cyc();
        check("cap_pushes", 64'(npush), 64'd10);
        check("cap_issued", 64'(issued.size()), 64'd8);
        check("cap_out_valid", 64'(out_valid), 64'd0);
        check("cap_inflight", 64'(inflight_o), 64'd8);
        rsp_valid = 1;
        cyc();
        rsp_valid = 0;
        cyc();
        check("cap_ninth", 64'(issued.size()), 64'd9);
        check("cap_ninth_tag", 64'(issued[8]), 64'd18);
        settle();

        // Kill with queued and in-flight requests
        fill(20, 4);
        out_ready = 1;
        cyc();
        cyc();
        out_ready = 0;
        set_in(1, 24);
        cyc();
        in_valid = 0;
        check("kill_pre_count", 64'(count_o), 64'd3);
        check("kill_pre_infl", 64'(inflight_o), 64'd2);
        kill = 1;
        cyc();
        kill = 0;
        check("kill_count", 64'(count_o), 64'd0);
        check("kill_inflight", 64'(inflight_o), 64'd2);
        out_ready = 1;
        for (int i = 0; i < 3; i++) cyc();
        check("kill_no_valid", 64'(out_valid), 64'd0);
        set_in(1, 25);
        cyc();
        in_valid = 0;
        check("kill_new_valid", 64'(out_valid), 64'd1);
        check("kill_new_tag", 64'(out_tag), 64'd25);
        settle();

        // Fence drain
        fill(30, 3);
        out_ready = 1;
        cyc();
        drain = 1;
        set_in(1, 40);
        #1;
        check("drain_in_ready", 64'(in_ready), 64'd0);
        cyc();
        cyc();
        in_valid = 0;
        check("drain_count", 64'(count_o), 64'd0);
        check("drain_infl3", 64'(inflight_o), 64'd3);
        check("drain_not_yet", 64'(drained), 64'd0);
        rsp_valid = 1;
        for (int i = 0; i < 3; i++) cyc();
        rsp_valid = 0;
        check("drain_done", 64'(drained), 64'd1);
        cyc();
        drain = 0;
        cyc();
        check("drain_release", 64'(in_ready), 64'd1);
        settle();

        // Async reset mid-burst
        fill(50, 4);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 60 + i);
            cyc();
        end
        in_valid = 0;
        cyc();
        check("burst_count", 64'(count_o), 64'd3);
        check("burst_infl", 64'(inflight_o), 64'd5);
        #2;
        rstn = 0;
        #1;
        check("areset_count", 64'(count_o), 64'd0);
        check("areset_infl", 64'(inflight_o), 64'd0);
        check("areset_valid", 64'(out_valid), 64'd0);
        check("areset_drained", 64'(drained), 64'd1);
        q.delete();
        infl = 0;
        @(posedge clk);
        #1;
        check("areset_hold", 64'(out_valid), 64'd0);
        @(negedge clk);
        rstn = 1;
        out_ready = 0;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 9) < 7, int'($urandom_range(0, 127)));
            out_ready = $urandom_range(0, 9) < 6;
            rsp_valid = $urandom_range(0, 9) < 4;
            kill      = $urandom_range(0, 99) < 3;
            drain     = $urandom_range(0, 99) < 6;
            cyc();
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
